// File: rtl/tlul_pkg.sv
// TileLink-UL host-to-device and device-to-host channel bundles.
package tlul_pkg;
    typedef struct packed {
        logic                        a_valid;
        logic [2:0]                  a_opcode;
        logic [2:0]                  a_param;
        logic [top_pkg::TL_SZW-1:0]  a_size;
        logic [top_pkg::TL_AIW-1:0]  a_source;
        logic [top_pkg::TL_AW-1:0]   a_address;
        logic [top_pkg::TL_DBW-1:0]  a_mask;
        logic [top_pkg::TL_DW-1:0]   a_data;
        logic [top_pkg::TL_AUW-1:0]  a_user;
        logic                        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                        d_valid;
        logic [2:0]                  d_opcode;
        logic [2:0]                  d_param;
        logic [top_pkg::TL_SZW-1:0]  d_size;
        logic [top_pkg::TL_AIW-1:0]  d_source;
        logic [top_pkg::TL_DIW-1:0]  d_sink;
        logic [top_pkg::TL_DW-1:0]   d_data;
        logic [top_pkg::TL_DUW-1:0]  d_user;
        logic                        d_error;
        logic                        a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// Bus-width constants shared by the TL-UL types.
package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_AUW = 21;
    localparam int TL_DUW = 14;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;
endpackage

// File: rtl/tlul_host_arb2.sv
// Two-host TL-UL arbiter: round-robin A-channel grant with lock-until-handshake,
// host index carried in a_source MSB, per-host outstanding count, D-channel routing.
module tlul_host_arb2 #(
    parameter int MaxOutstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_h_i [2],
    output tlul_pkg::tl_d2h_t tl_h_o [2],
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i,
    output logic              busy_o,
    output logic              err_o
);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int SrcW = top_pkg::TL_AIW;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            lock;
    logic            lock_idx;
    logic            last_idx;
    logic [CntW-1:0] cnt [2];

    logic [1:0] elig;
    logic       gnt_vld;
    logic       gnt;
    logic       a_req_vld;
    logic       a_hs;
    logic       tgt;
    logic       matched;
    logic       d_fwd;
    logic       d_hs;
    logic       d_drop;
    logic       d_ready_dev;
    logic [1:0] cnt_inc;
    logic [1:0] cnt_dec;

    // A-channel grant: a pending lock overrides eligibility so the held payload stays put
    always_comb begin
        elig[0] = tl_h_i[0].a_valid && (cnt[0] != MaxCnt);
        elig[1] = tl_h_i[1].a_valid && (cnt[1] != MaxCnt);
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (lock) begin
            gnt_vld = 1'b1;
            gnt     = lock_idx;
        end else if (elig[0] && elig[1]) begin
            gnt_vld = 1'b1;
            gnt     = !last_idx;
        end else if (elig[0]) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
        end else if (elig[1]) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
        end
    end

    assign a_req_vld = !rst_i && gnt_vld && tl_h_i[gnt].a_valid;
    assign a_hs      = a_req_vld && tl_d_i.a_ready;

    // D-channel target comes from the source MSB stamped on the way out
    assign tgt         = tl_d_i.d_source[SrcW-1];
    assign matched     = (cnt[tgt] != '0);
    assign d_fwd       = tl_d_i.d_valid && matched;
    assign d_hs        = d_fwd && tl_h_i[tgt].d_ready;
    assign d_drop      = tl_d_i.d_valid && !matched;
    assign d_ready_dev = !rst_i && (matched ? tl_h_i[tgt].d_ready : 1'b1);

    assign cnt_inc = {a_hs &  gnt, a_hs & ~gnt};
    assign cnt_dec = {d_hs &  tgt, d_hs & ~tgt};

    always_comb begin
        tl_d_o          = tl_h_i[gnt];
        tl_d_o.a_source = {gnt, tl_h_i[gnt].a_source[SrcW-2:0]};
        tl_d_o.a_valid  = a_req_vld;
        tl_d_o.d_ready  = d_ready_dev;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            tl_h_o[i]                  = tl_d_i;
            tl_h_o[i].d_source[SrcW-1] = 1'b0;
            tl_h_o[i].d_valid          = !rst_i && d_fwd && (tgt == 1'(i));
            tl_h_o[i].a_ready          = !rst_i && gnt_vld && (gnt == 1'(i)) && tl_d_i.a_ready;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock     <= 1'b0;
            lock_idx <= 1'b0;
            last_idx <= 1'b1;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= d_drop;
            if (a_hs) begin
                lock     <= 1'b0;
                last_idx <= gnt;
            end else if (a_req_vld) begin
                lock     <= 1'b1;
                lock_idx <= gnt;
            end
            // A and D on the same host in one cycle cancel out
            for (int i = 0; i < 2; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    cnt[i] <= cnt[i] - CntW'(1);
                end
            end
        end
    end

    assign busy_o = (|cnt[0]) | (|cnt[1]);

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Bench for tlul_host_arb2: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    localparam int   MaxOut = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h2d     [2];
    tl_d2h_t d2h     [2];
    tl_h2d_t dev_req;
    tl_d2h_t dev_rsp;
    logic    busy;
    logic    err;

    logic        hv    [2];
    logic [7:0]  hsrc  [2];
    logic [31:0] haddr [2];
    logic        hdr   [2];
    logic        ar;
    logic        dv;
    logic [7:0]  ds;
    logic [31:0] ddata;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            h2d[i]           = '0;
            h2d[i].a_valid   = hv[i];
            h2d[i].a_source  = hsrc[i];
            h2d[i].a_address = haddr[i];
            h2d[i].a_data    = ~haddr[i];
            h2d[i].a_mask    = '1;
            h2d[i].d_ready   = hdr[i];
        end
        dev_rsp          = '0;
        dev_rsp.d_valid  = dv;
        dev_rsp.d_source = ds;
        dev_rsp.d_data   = ddata;
        dev_rsp.a_ready  = ar;
    end

    tlul_host_arb2 #(.MaxOutstanding(MaxOut)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h_i (h2d),
        .tl_h_o (d2h),
        .tl_d_o (dev_req),
        .tl_d_i (dev_rsp),
        .busy_o (busy),
        .err_o  (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: outstanding counts, pending-lock owner, last winner
    int   m_cnt [2];
    int   m_lock;
    int   m_last;
    logic m_err;

    logic       m_gv, m_g, m_t, m_match;
    logic       e_av, e_drdy, e_busy, dhs, dhold;
    logic [7:0] e_src;
    logic       e_ardy [2];
    logic       e_dv   [2];
    logic       ahs    [2];

    task automatic model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_lock   = -1;
        m_last   = 1;
        m_err    = 1'b0;
        ahs[0]   = 1'b0;
        ahs[1]   = 1'b0;
        dhold    = 1'b0;
    endtask

    task automatic model_eval();
        logic el [2];
        for (int i = 0; i < 2; i++) el[i] = hv[i] && (m_cnt[i] < MaxOut);
        m_gv = 1'b0;
        m_g  = 1'b0;
        if (m_lock >= 0) begin
            m_gv = 1'b1;
            m_g  = (m_lock == 1);
        end else if (el[0] && el[1]) begin
            m_gv = 1'b1;
            m_g  = (m_last == 0);
        end else if (el[0] || el[1]) begin
            m_gv = 1'b1;
            m_g  = el[1];
        end
        e_av  = m_gv && hv[m_g];
        e_src = {m_g, hsrc[m_g][6:0]};
        for (int i = 0; i < 2; i++) begin
            e_ardy[i] = m_gv && (int'(m_g) == i) && ar;
            ahs[i]    = e_ardy[i] && e_av;
        end
        m_t     = ds[7];
        m_match = (m_cnt[m_t] > 0);
        for (int i = 0; i < 2; i++) e_dv[i] = dv && m_match && (int'(m_t) == i);
        e_drdy = m_match ? hdr[m_t] : 1'b1;
        dhs    = dv && m_match && hdr[m_t];
        dhold  = dv && m_match && !hdr[m_t];
        e_busy = (m_cnt[0] != 0) || (m_cnt[1] != 0);
    endtask

    task automatic model_compare();
        chk("a_valid", 32'(dev_req.a_valid), 32'(e_av));
        if (e_av) begin
            chk("a_source", 32'(dev_req.a_source), 32'(e_src));
            chk("a_address", dev_req.a_address, haddr[m_g]);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a_ready%0d", i), 32'(d2h[i].a_ready), 32'(e_ardy[i]));
            chk($sformatf("d_valid%0d", i), 32'(d2h[i].d_valid), 32'(e_dv[i]));
            if (e_dv[i]) begin
                chk($sformatf("d_source%0d", i), 32'(d2h[i].d_source), 32'({1'b0, ds[6:0]}));
                chk($sformatf("d_data%0d", i), d2h[i].d_data, ddata);
            end
        end
        chk("d_ready", 32'(dev_req.d_ready), 32'(e_drdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic model_commit();
        m_err = dv && !m_match;
        if (e_av && ar) begin
            m_cnt[m_g] = m_cnt[m_g] + 1;
            m_last     = int'(m_g);
            m_lock     = -1;
        end else if (e_av) begin
            m_lock = int'(m_g);
        end
        if (dhs) m_cnt[m_t] = m_cnt[m_t] - 1;
    endtask

    task automatic tick(input bit mcheck);
        model_eval();
        if (mcheck) model_compare();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, 32'(dev_req.a_valid), 32'(0));
        chk({tag, "_a_ready0"}, 32'(d2h[0].a_ready), 32'(0));
        chk({tag, "_a_ready1"}, 32'(d2h[1].a_ready), 32'(0));
        chk({tag, "_d_valid0"}, 32'(d2h[0].d_valid), 32'(0));
        chk({tag, "_d_valid1"}, 32'(d2h[1].d_valid), 32'(0));
        chk({tag, "_d_ready"}, 32'(dev_req.d_ready), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(0));
    endtask

    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            if (ahs[i] || !hv[i]) begin
                hv[i]    = ($urandom_range(99, 0) < 60);
                hsrc[i]  = 8'($urandom);
                haddr[i] = $urandom;
            end
            hdr[i] = ($urandom_range(99, 0) < 75);
        end
        ar = ($urandom_range(99, 0) < 70);
        if (!dhold) begin
            dv    = ($urandom_range(99, 0) < 50);
            ddata = $urandom;
            if ($urandom_range(9, 0) == 0) ds = 8'($urandom);
            else if (m_cnt[0] > 0 && (m_cnt[1] == 0 || $urandom_range(1, 0) == 0)) ds = {1'b0, 7'($urandom)};
            else ds = {1'b1, 7'($urandom)};
        end
    endtask

    typedef struct packed {
        logic       hv0, hv1, ar, dv;
        logic [7:0] ds;
        logic       dr0, dr1;
        logic       e_av;
        logic [7:0] e_src;
        logic       e_ar0, e_ar1, e_dv0, e_dv1;
        logic [7:0] e_dsrc;
        logic       e_drdy, e_busy, e_err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // hv0 hv1 ar dv ds dr0 dr1 | av src ar0 ar1 dv0 dv1 dsrc drdy busy err
        vecs[0]  = '{H, H, H, L, 8'h00, H, H, H, 8'h05, H, L, L, L, 8'h00, H, L, L};
        vecs[1]  = '{H, H, H, L, 8'h00, H, H, H, 8'h8A, L, H, L, L, 8'h00, H, H, L};
        vecs[2]  = '{H, H, H, H, 8'h05, H, H, H, 8'h05, H, L, H, L, 8'h05, H, H, L};
        vecs[3]  = '{H, H, L, H, 8'h8A, H, L, H, 8'h8A, L, L, L, H, 8'h0A, L, H, L};
        vecs[4]  = '{H, H, L, H, 8'h8A, H, H, H, 8'h8A, L, L, L, H, 8'h0A, H, H, L};
        vecs[5]  = '{H, H, H, L, 8'h00, H, H, H, 8'h8A, L, H, L, L, 8'h00, H, H, L};
        vecs[6]  = '{H, H, H, L, 8'h00, H, H, H, 8'h05, H, L, L, L, 8'h00, H, H, L};
        vecs[7]  = '{L, L, H, H, 8'h8A, H, H, L, 8'h00, L, L, L, H, 8'h0A, H, H, L};
        vecs[8]  = '{L, L, H, H, 8'h85, H, H, L, 8'h00, L, L, L, L, 8'h00, H, H, L};
        vecs[9]  = '{L, L, H, L, 8'h00, H, H, L, 8'h00, L, L, L, L, 8'h00, H, H, H};
        vecs[10] = '{L, L, H, H, 8'h00, H, H, L, 8'h00, L, L, H, L, 8'h00, H, H, L};
        vecs[11] = '{L, L, H, H, 8'h7F, H, H, L, 8'h00, L, L, H, L, 8'h7F, H, H, L};
        vecs[12] = '{L, L, H, L, 8'h00, H, H, L, 8'h00, L, L, L, L, 8'h00, H, L, L};

        rst      = 1'b1;
        hv[0]    = 1'b1;
        hv[1]    = 1'b1;
        hsrc[0]  = 8'h85;
        hsrc[1]  = 8'h0A;
        haddr[0] = 32'h0000_1000;
        haddr[1] = 32'h0000_2000;
        hdr[0]   = 1'b1;
        hdr[1]   = 1'b1;
        ar       = 1'b1;
        dv       = 1'b0;
        ds       = 8'h00;
        ddata    = 32'hCAFE_0000;
        model_reset();

        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;

        for (int k = 0; k < 13; k++) begin
            hv[0]  = vecs[k].hv0;
            hv[1]  = vecs[k].hv1;
            ar     = vecs[k].ar;
            dv     = vecs[k].dv;
            ds     = vecs[k].ds;
            hdr[0] = vecs[k].dr0;
            hdr[1] = vecs[k].dr1;
            #2;
            chk($sformatf("v%0d_a_valid", k), 32'(dev_req.a_valid), 32'(vecs[k].e_av));
            if (vecs[k].e_av) chk($sformatf("v%0d_a_source", k), 32'(dev_req.a_source), 32'(vecs[k].e_src));
            chk($sformatf("v%0d_a_ready0", k), 32'(d2h[0].a_ready), 32'(vecs[k].e_ar0));
            chk($sformatf("v%0d_a_ready1", k), 32'(d2h[1].a_ready), 32'(vecs[k].e_ar1));
            chk($sformatf("v%0d_d_valid0", k), 32'(d2h[0].d_valid), 32'(vecs[k].e_dv0));
            chk($sformatf("v%0d_d_valid1", k), 32'(d2h[1].d_valid), 32'(vecs[k].e_dv1));
            if (vecs[k].e_dv0) chk($sformatf("v%0d_d_source0", k), 32'(d2h[0].d_source), 32'(vecs[k].e_dsrc));
            if (vecs[k].e_dv1) chk($sformatf("v%0d_d_source1", k), 32'(d2h[1].d_source), 32'(vecs[k].e_dsrc));
            chk($sformatf("v%0d_d_ready", k), 32'(dev_req.d_ready), 32'(vecs[k].e_drdy));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
            chk($sformatf("v%0d_err", k), 32'(err), 32'(vecs[k].e_err));
            tick(1'b0);
        end

        // Outstanding limit on host 0
        hv[0] = 1'b1; hv[1] = 1'b0; ar = 1'b1; dv = 1'b0; ds = 8'h00;
        repeat (4) begin #2; tick(1'b1); end
        hv[1] = 1'b1;
        #2;
        chk("lim_a_ready0", 32'(d2h[0].a_ready), 32'(0));
        chk("lim_a_ready1", 32'(d2h[1].a_ready), 32'(1));
        chk("lim_a_source", 32'(dev_req.a_source), 32'h8A);
        tick(1'b1);
        hv[1] = 1'b0;
        #2;
        chk("lim_stall_valid", 32'(dev_req.a_valid), 32'(0));
        tick(1'b1);
        dv = 1'b1; ds = 8'h03;
        #2;
        chk("lim_rsp_valid0", 32'(d2h[0].d_valid), 32'(1));
        chk("lim_rsp_source0", 32'(d2h[0].d_source), 32'h03);
        chk("lim_rsp_valid1", 32'(d2h[1].d_valid), 32'(0));
        tick(1'b1);
        dv = 1'b0;
        #2;
        chk("lim_release", 32'(d2h[0].a_ready), 32'(1));
        tick(1'b1);
        hv[0] = 1'b0; dv = 1'b1; ds = 8'h00;
        repeat (4) begin #2; tick(1'b1); end
        ds = 8'h80;
        #2; tick(1'b1);
        dv = 1'b0;
        #2;
        chk("lim_busy_idle", 32'(busy), 32'(0));
        tick(1'b1);

        // Simultaneous A and D handshake on host 1 at count 2
        hv[1] = 1'b1;
        repeat (2) begin #2; tick(1'b1); end
        dv = 1'b1; ds = 8'h80;
        #2;
        chk("ad_a_ready1", 32'(d2h[1].a_ready), 32'(1));
        chk("ad_d_valid1", 32'(d2h[1].d_valid), 32'(1));
        tick(1'b1);
        hv[1] = 1'b0;
        #2; chk("ad_rsp_a", 32'(d2h[1].d_valid), 32'(1)); tick(1'b1);
        #2; chk("ad_rsp_b", 32'(d2h[1].d_valid), 32'(1)); tick(1'b1);
        #2;
        chk("ad_busy_idle", 32'(busy), 32'(0));
        chk("ad_drop_valid1", 32'(d2h[1].d_valid), 32'(0));
        chk("ad_drop_ready", 32'(dev_req.d_ready), 32'(1));
        tick(1'b1);
        dv = 1'b0;
        #2; chk("ad_err_pulse", 32'(err), 32'(1)); tick(1'b1);
        #2; chk("ad_err_clear", 32'(err), 32'(0)); tick(1'b1);

        // Lock: host 1 held while host 0 waits
        hv[0] = 1'b0; hv[1] = 1'b1; ar = 1'b0;
        #2; chk("lock_first_src", 32'(dev_req.a_source), 32'h8A); tick(1'b1);
        hv[0] = 1'b1;
        repeat (3) begin
            #2;
            chk("lock_hold_src", 32'(dev_req.a_source), 32'h8A);
            chk("lock_hold_addr", dev_req.a_address, 32'h0000_2000);
            tick(1'b1);
        end
        ar = 1'b1;
        #2; chk("lock_hs_ready1", 32'(d2h[1].a_ready), 32'(1)); tick(1'b1);
        #2;
        chk("lock_next_src", 32'(dev_req.a_source), 32'h05);
        chk("lock_next_ready0", 32'(d2h[0].a_ready), 32'(1));
        tick(1'b1);
        hv[0] = 1'b0; hv[1] = 1'b0; dv = 1'b1; ds = 8'h80;
        #2; tick(1'b1);
        ds = 8'h00;
        #2; tick(1'b1);
        dv = 1'b0;
        #2; tick(1'b1);

        // Randomized traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                #2;
                chk_reset_outputs("midrst");
                model_reset();
                @(posedge clk);
                #1;
                rst   = 1'b0;
                hv[0] = 1'b0; hv[1] = 1'b0; dv = 1'b1; ds = 8'h85; hdr[1] = 1'b1;
                #2;
                chk("stale_valid1", 32'(d2h[1].d_valid), 32'(0));
                chk("stale_ready", 32'(dev_req.d_ready), 32'(1));
                tick(1'b1);
                dv = 1'b0;
                #2;
                chk("stale_err", 32'(err), 32'(1));
                tick(1'b1);
            end
            drive_random();
            #2;
            tick(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
